// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU with a single registered output stage.
// Shifts (lsl/asr) run one bit per cycle in a SHIFT state by default.
// Defining ALU_PIPE_BARREL_EN selects a single-cycle barrel shifter instead;
// in that build the SHIFT state is never entered and busy is tied low.
module alu_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             out_err,
  output logic             busy
);

  localparam int unsigned SW  = $clog2(WIDTH);
  localparam int unsigned WP1 = WIDTH + 1;

  localparam logic [OPW-1:0] OP_ADD    = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_ADDINC = OPW'(5'b00001);
  localparam logic [OPW-1:0] OP_INCA   = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUBDEC = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_SUB    = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_DECA   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_LSL    = OPW'(5'b01000);
  localparam logic [OPW-1:0] OP_ASR    = OPW'(5'b01001);
  localparam logic [OPW-1:0] OP_ZERO   = OPW'(5'b10000);
  localparam logic [OPW-1:0] OP_AND    = OPW'(5'b10001);
  localparam logic [OPW-1:0] OP_NAANDB = OPW'(5'b10010);
  localparam logic [OPW-1:0] OP_PASSB  = OPW'(5'b10011);
  localparam logic [OPW-1:0] OP_AANDNB = OPW'(5'b10100);
  localparam logic [OPW-1:0] OP_PASSA  = OPW'(5'b10101);
  localparam logic [OPW-1:0] OP_XOR    = OPW'(5'b10110);
  localparam logic [OPW-1:0] OP_OR     = OPW'(5'b10111);
  localparam logic [OPW-1:0] OP_NOR    = OPW'(5'b11000);
  localparam logic [OPW-1:0] OP_XNOR   = OPW'(5'b11001);
  localparam logic [OPW-1:0] OP_NOTA   = OPW'(5'b11010);
  localparam logic [OPW-1:0] OP_NAORB  = OPW'(5'b11011);
  localparam logic [OPW-1:0] OP_NOTB   = OPW'(5'b11100);
  localparam logic [OPW-1:0] OP_AORNB  = OPW'(5'b11101);
  localparam logic [OPW-1:0] OP_NAND   = OPW'(5'b11110);
  localparam logic [OPW-1:0] OP_ONES   = OPW'(5'b11111);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             sh_asr_q;
  logic             sh_c_q, sh_c_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             err_q;

  logic             out_free, accept, start_shift, sh_done;
  logic [SW-1:0]    amt;
  logic [WIDTH-1:0] x;
  logic             cin, arith, is_shift;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_err;
  logic             wr_en, wr_err;
  logic [WIDTH-1:0] wr_res;
  logic [3:0]       wr_flags;

  assign amt      = b[SW-1:0];
  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q == IDLE) && out_free;
  assign accept   = in_valid && in_ready;

`ifdef ALU_PIPE_BARREL_EN
  // Barrel shifts carry one extra bit so the last bit shifted out falls into it.
  logic [WIDTH:0] lsl_w, asr_w;
  assign lsl_w = {1'b0, a} << amt;
  assign asr_w = $signed({a, 1'b0}) >>> amt;
  assign start_shift = 1'b0;
`else
  assign start_shift = accept && is_shift && (amt != '0);
`endif

  // Single-cycle operation decode: adder operand/carry-in select and logic ops.
  always_comb begin
    x        = '0;
    cin      = 1'b0;
    arith    = 1'b0;
    is_shift = 1'b0;
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_err  = 1'b0;
    case (opcode)
      OP_ADD:    begin arith = 1'b1; x = b; end
      OP_ADDINC: begin arith = 1'b1; x = b; cin = 1'b1; end
      OP_INCA:   begin arith = 1'b1; cin = 1'b1; end
      OP_SUBDEC: begin arith = 1'b1; x = ~b; end
      OP_SUB:    begin arith = 1'b1; x = ~b; cin = 1'b1; end
      OP_DECA:   begin arith = 1'b1; x = '1; end
      OP_LSL, OP_ASR: begin
        is_shift = 1'b1;
`ifdef ALU_PIPE_BARREL_EN
        if (opcode == OP_LSL) begin
          alu_res = lsl_w[WIDTH-1:0];
          alu_c   = lsl_w[WIDTH];
        end else begin
          alu_res = asr_w[WIDTH:1];
          alu_c   = asr_w[0];
        end
`else
        // Only a zero shift amount completes here; others go through SHIFT.
        alu_res = a;
`endif
      end
      OP_ZERO:   alu_res = '0;
      OP_AND:    alu_res = a & b;
      OP_NAANDB: alu_res = ~a & b;
      OP_PASSB:  alu_res = b;
      OP_AANDNB: alu_res = a & ~b;
      OP_PASSA:  alu_res = a;
      OP_XOR:    alu_res = a ^ b;
      OP_OR:     alu_res = a | b;
      OP_NOR:    alu_res = ~a & ~b;
      OP_XNOR:   alu_res = ~(a ^ b);
      OP_NOTA:   alu_res = ~a;
      OP_NAORB:  alu_res = ~a | b;
      OP_NOTB:   alu_res = ~b;
      OP_AORNB:  alu_res = a | ~b;
      OP_NAND:   alu_res = ~a | ~b;
      OP_ONES:   alu_res = '1;
      default:   alu_err = 1'b1;
    endcase
    sum = {1'b0, a} + {1'b0, x} + WP1'(cin);
    if (arith) begin
      alu_res = sum[WIDTH-1:0];
      alu_c   = sum[WIDTH];
      alu_v   = (a[WIDTH-1] == x[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end
  end

  // One iterative shift step; finishing is allowed only when the output slot is free.
  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    sh_c_d = sh_c_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - SW'(1);
      if (sh_asr_q) begin
        sh_d   = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
        sh_c_d = sh_q[0];
      end else begin
        sh_d   = {sh_q[WIDTH-2:0], 1'b0};
        sh_c_d = sh_q[WIDTH-1];
      end
    end
    sh_done = (state_q == SHIFT) && (cnt_d == '0) && out_free;
  end

  // Output-register write source: finished shift or a single-cycle operation.
  always_comb begin
    wr_en    = 1'b0;
    wr_res   = '0;
    wr_flags = '0;
    wr_err   = 1'b0;
    if (sh_done) begin
      wr_en    = 1'b1;
      wr_res   = sh_d;
      wr_flags = {sh_d[WIDTH-1], (sh_d == '0), sh_c_d, 1'b0};
    end else if (accept && !start_shift) begin
      wr_en    = 1'b1;
      wr_res   = alu_res;
      wr_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
      wr_err   = alu_err;
    end
  end

  // Control FSM, shift datapath and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      sh_asr_q    <= 1'b0;
      sh_c_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      if (wr_en) begin
        out_valid_q <= 1'b1;
        result_q    <= wr_res;
        flags_q     <= wr_flags;
        err_q       <= wr_err;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start_shift) begin
            state_q  <= SHIFT;
            cnt_q    <= amt;
            sh_q     <= a;
            sh_asr_q <= (opcode == OP_ASR);
            sh_c_q   <= 1'b0;
          end
        end
        SHIFT: begin
          sh_q   <= sh_d;
          cnt_q  <= cnt_d;
          sh_c_q <= sh_c_d;
          if (sh_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign out_err   = err_q;
`ifdef ALU_PIPE_BARREL_EN
  assign busy = 1'b0;
`else
  assign busy = (state_q == SHIFT);
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed cases plus random traffic against a reference model.
`timescale 1ns/1ps
module tb_alu_pipe;
  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, out_err, busy;
  logic [4:0]    opcode;
  logic [W-1:0]  a, b, result;
  logic [3:0]    flags;

  int total = 0;
  int bad   = 0;

  alu_pipe #(.WIDTH(W), .OPW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: {err, N, Z, C, V, result} from plain integer arithmetic.
  function automatic logic [36:0] model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, s;
    logic [63:0] ux, uy, u;
    logic [31:0] r;
    logic        c, v, err, ar;
    int          amt;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    u = '0; s = 0; r = '0; c = 1'b0; v = 1'b0; err = 1'b0; ar = 1'b0;
    amt = int'(y[4:0]);
    case (op)
      5'b00000: begin ar = 1'b1; s = sx + sy;     u = ux + uy;     c = u[32]; end
      5'b00001: begin ar = 1'b1; s = sx + sy + 1; u = ux + uy + 1; c = u[32]; end
      5'b00011: begin ar = 1'b1; s = sx + 1;      c = (x == 32'hFFFF_FFFF); end
      5'b00100: begin ar = 1'b1; s = sx - sy - 1; c = (x > y); end
      5'b00101: begin ar = 1'b1; s = sx - sy;     c = (x >= y); end
      5'b00110: begin ar = 1'b1; s = sx - 1;      c = (x != 32'd0); end
      5'b01000: begin
        u = ux << amt; r = u[31:0];
        if (amt != 0) c = u[32];
      end
      5'b01001: begin
        s = sx >>> amt; r = s[31:0];
        if (amt != 0) c = x[amt-1];
      end
      5'b10000: r = '0;
      5'b10001: r = x & y;
      5'b10010: r = ~x & y;
      5'b10011: r = y;
      5'b10100: r = x & ~y;
      5'b10101: r = x;
      5'b10110: r = x ^ y;
      5'b10111: r = x | y;
      5'b11000: r = ~x & ~y;
      5'b11001: r = ~(x ^ y);
      5'b11010: r = ~x;
      5'b11011: r = ~x | y;
      5'b11100: r = ~y;
      5'b11101: r = x | ~y;
      5'b11110: r = ~x | ~y;
      5'b11111: r = '1;
      default:  err = 1'b1;
    endcase
    if (ar) begin
      r = s[31:0];
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
    return {err, r[31], (r == 32'd0), c, v, r};
  endfunction

  // Cycles from acceptance to the first cycle out_valid is seen.
  function automatic int exp_lat(input logic [4:0] op, input logic [31:0] y);
    int l;
    l = 1;
`ifndef ALU_PIPE_BARREL_EN
    if ((op == 5'b01000 || op == 5'b01001) && y[4:0] != 5'd0) l = int'(y[4:0]) + 1;
`endif
    return l;
  endfunction

  // Issue one op with out_ready high and wait for its result.
  task automatic run_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                        output logic [36:0] obs, output int lat, output int busy_cyc, output bit ok);
    int guard;
    ok = 1'b1; lat = 0; busy_cyc = 0; obs = '0; guard = 0;
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    while (!in_ready && guard < 100) begin @(negedge clk); #1; guard++; end
    if (!in_ready) ok = 1'b0;
    opcode = op; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; opcode = 5'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    if (!out_valid) ok = 1'b0;
    obs = {out_err, flags, result};
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; opcode = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if ({out_err, flags, result} !== 37'd0) begin bad++; $display("FAIL reset_outputs: got %h want 0", {out_err, flags, result}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_arith();
    logic [36:0] obs, exp;
    logic [4:0]  ops [6] = '{5'b00000, 5'b00001, 5'b00011, 5'b00100, 5'b00101, 5'b00110};
    logic [4:0]  op;
    logic [31:0] x, y;
    int lat, bc; bit ok;
    run_op(5'b00000, 32'hFFFF_FFFF, 32'h0000_0001, obs, lat, bc, ok);
    total++; if (!ok || obs !== {1'b0, 4'b0110, 32'h0}) begin bad++; $display("FAIL add_wrap: got %h want %h", obs, {1'b0, 4'b0110, 32'h0}); end
    total++; if (lat !== 1) begin bad++; $display("FAIL add_latency: got %0d want 1", lat); end
    run_op(5'b00101, 32'h8000_0000, 32'h0000_0001, obs, lat, bc, ok);
    total++; if (!ok || obs !== {1'b0, 4'b0011, 32'h7FFF_FFFF}) begin bad++; $display("FAIL sub_ovf: got %h want %h", obs, {1'b0, 4'b0011, 32'h7FFF_FFFF}); end
    for (int i = 0; i < 30; i++) begin
      op = ops[$urandom_range(0, 5)];
      x = (i % 5 == 0) ? 32'h7FFF_FFFF : $urandom;
      y = (i % 7 == 0) ? x : $urandom;
      exp = model(op, x, y);
      run_op(op, x, y, obs, lat, bc, ok);
      total++; if (!ok || obs !== exp || lat !== 1) begin bad++; $display("FAIL arith op=%b a=%h b=%h: got %h lat=%0d want %h lat=1", op, x, y, obs, lat, exp); end
    end
  endtask

  task automatic test_shift();
    logic [36:0] obs, exp;
    logic [4:0]  op;
    logic [31:0] x, y;
    int lat, bc, el; bit ok;
    run_op(5'b01001, 32'h8000_0010, 32'd4, obs, lat, bc, ok);
    el = exp_lat(5'b01001, 32'd4);
    total++; if (!ok || obs !== {1'b0, 4'b1000, 32'hF800_0001}) begin bad++; $display("FAIL asr4: got %h want %h", obs, {1'b0, 4'b1000, 32'hF800_0001}); end
    total++; if (lat !== el) begin bad++; $display("FAIL asr4_latency: got %0d want %0d", lat, el); end
    total++; if (bc !== el - 1) begin bad++; $display("FAIL asr4_busy: got %0d want %0d", bc, el - 1); end
    for (int i = 0; i < 16; i++) begin
      op = ($urandom_range(0, 1) != 0) ? 5'b01000 : 5'b01001;
      x = $urandom;
      y = $urandom;
      if (i == 0) y[4:0] = 5'd0;
      if (i == 1) y[4:0] = 5'd31;
      if (i == 2) y[4:0] = 5'd1;
      exp = model(op, x, y);
      el = exp_lat(op, y);
      run_op(op, x, y, obs, lat, bc, ok);
      total++; if (!ok || obs !== exp || lat !== el || bc !== el - 1) begin bad++; $display("FAIL shift op=%b a=%h amt=%0d: got %h lat=%0d busy=%0d want %h lat=%0d busy=%0d", op, x, y[4:0], obs, lat, bc, exp, el, el - 1); end
    end
  endtask

  task automatic test_logic_undef();
    logic [36:0] obs, exp;
    logic [4:0]  op;
    logic [31:0] x, y;
    int lat, bc; bit ok;
    run_op(5'b01100, 32'h1234_5678, 32'h9ABC_DEF0, obs, lat, bc, ok);
    total++; if (!ok || obs !== {1'b1, 4'b0100, 32'h0}) begin bad++; $display("FAIL undef_01100: got %h want %h", obs, {1'b1, 4'b0100, 32'h0}); end
    for (int i = 0; i < 24; i++) begin
      op = (i < 16) ? 5'(5'b10000 + i) : 5'($urandom);
      if (op == 5'b01000 || op == 5'b01001) op = 5'b00010;
      x = $urandom;
      y = $urandom;
      exp = model(op, x, y);
      run_op(op, x, y, obs, lat, bc, ok);
      total++; if (!ok || obs !== exp || lat !== 1) begin bad++; $display("FAIL logic op=%b a=%h b=%h: got %h lat=%0d want %h lat=1", op, x, y, obs, lat, exp); end
    end
  endtask

  task automatic test_backpressure();
    logic [36:0] e1, e2, cur;
    logic [31:0] x1, y1, x2, y2;
    x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
    e1 = model(5'b00000, x1, y1);
    e2 = model(5'b10110, x2, y2);
    @(negedge clk);
    out_ready = 1'b0; opcode = 5'b00000; a = x1; b = y1; in_valid = 1'b1;
    @(negedge clk);
    opcode = 5'b10110; a = x2; b = y2;
    for (int i = 0; i < 3; i++) begin
      #1;
      cur = {out_err, flags, result};
      total++; if (out_valid !== 1'b1 || cur !== e1) begin bad++; $display("FAIL bp_hold%0d: got v=%b %h want v=1 %h", i, out_valid, cur, e1); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    cur = {out_err, flags, result};
    total++; if (out_valid !== 1'b1 || cur !== e2) begin bad++; $display("FAIL bp_second: got v=%b %h want v=1 %h", out_valid, cur, e2); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [36:0] q[$];
    logic [36:0] held, cur, exp;
    bit hold, acc;
    int sent, got, cyc;
    hold = 1'b0; acc = 1'b0; sent = 0; got = 0; cyc = 0; held = '0;
    in_valid = 1'b0;
    while (got < 40 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      cur = {out_err, flags, result};
      if (hold) begin
        total++; if (out_valid !== 1'b1 || cur !== held) begin bad++; $display("FAIL stream_hold: got v=%b %h want v=1 %h", out_valid, cur, held); end
      end
      if (acc) in_valid = 1'b0;
      acc = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < 40 && $urandom_range(0, 3) != 0) begin
        opcode = 5'($urandom); a = $urandom; b = $urandom; in_valid = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL stream_extra: got %h want no result", cur);
        end else begin
          exp = q.pop_front();
          if (cur !== exp) begin bad++; $display("FAIL stream_data: got %h want %h", cur, exp); end
        end
        got++;
      end
      hold = out_valid && !out_ready;
      held = cur;
      if (in_valid && in_ready) begin
        q.push_back(model(opcode, a, b));
        sent++;
        acc = 1'b1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (got != 40) begin bad++; $display("FAIL stream_timeout: got %0d results want 40", got); end
  endtask

  task automatic test_rst_mid_shift();
    bit seen;
    @(negedge clk);
    out_ready = 1'b1; opcode = 5'b01000; a = $urandom | 32'h1; b = 32'd20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_shift: got v=%b busy=%b rdy=%b want v=0 busy=0 rdy=1", out_valid, busy, in_ready); end
    total++; if (result !== 32'd0 || flags !== 4'd0) begin bad++; $display("FAIL rst_mid_shift_regs: got %h/%b want 0/0", result, flags); end
    seen = 1'b0;
    repeat (30) begin @(negedge clk); if (out_valid || busy) seen = 1'b1; end
    total++; if (seen) begin bad++; $display("FAIL rst_stale_result: got activity want none"); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_logic_undef();
    test_backpressure();
    test_back_to_back();
    test_rst_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal range 8..64).
REQ-002 SHALL have parameter OPW, default 5, opcode width (fixed encoding per REQ-012).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports in_valid (input, 1, operation offered) and in_ready (output, 1, operation accepted this cycle if in_valid).
REQ-006 SHALL have ports opcode (input, OPW, operation select), a (input, WIDTH, operand A) and b (input, WIDTH, operand B; low clog2(WIDTH) bits are the shift amount).
REQ-007 SHALL have ports out_valid (output, 1, result held), out_ready (input, 1, consumer takes result) and result (output, WIDTH, operation result).
REQ-008 SHALL have port flags, output, 4, {N,Z,C,V} registered with result.
REQ-009 SHALL have port out_err, output, 1, set with result when opcode was undefined.
REQ-010 SHALL have port busy, output, 1, high while in SHIFT state.

Function
REQ-011 SHALL accept an operation when in_valid && in_ready; operands and opcode are captured on that edge and later input changes are ignored.
REQ-012 SHALL decode: 00000 add A+B; 00001 addinc A+B+1; 00011 inca A+1; 00100 subdec A-B-1; 00101 sub A-B; 00110 deca A-1; 01000 lsl; 01001 asr; 10000 zeros; 10001 A&B; 10010 ~A&B; 10011 passb; 10100 A&~B; 10101 passa; 10110 A^B; 10111 A|B; 11000 ~A&~B; 11001 ~(A^B); 11010 ~A; 11011 ~A|B; 11100 ~B; 11101 A|~B; 11110 ~A|~B; 11111 all ones.
REQ-013 SHALL compute arithmetic in WIDTH+1 bits as A+X+cin (sub/subdec: X=~B, cin=1/0; deca: X=all ones, cin=0); C=bit WIDTH; V=signed overflow of the WIDTH-bit result.
REQ-014 SHALL set C=0 and V=0 for logic ops, zeros, ones and undefined opcodes; N=result[WIDTH-1] and Z=(result==0) for every op.
REQ-015 SHALL, for undefined opcodes (00010, 00111, 01010..01111), produce result=0, Z=1, out_err=1; out_err=0 otherwise.
REQ-016 SHALL deliver non-shift results with out_valid high on the cycle after acceptance (latency 1).
REQ-017 SHALL shift by amt=b[clog2(WIDTH)-1:0]; lsl fills zeros; asr replicates A[WIDTH-1]; C=last bit shifted out (lsl: old MSB, asr: old LSB); amt=0 gives result=A, C=0; V=0.
REQ-018 SHALL use states IDLE and SHIFT: IDLE->SHIFT on accepting a shift with amt>0 (iterative build); SHIFT shifts one bit per cycle, decrementing a counter; SHIFT->IDLE when counter reaches 0 and the output register is free, writing result.
REQ-019 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-020 SHALL hold result, flags, out_err and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL clear out_valid after out_valid && out_ready unless a new result is written on the same edge, in which case out_valid stays high with the new result.
REQ-022 SHALL stall SHIFT completion (counter at 0, state held) while out_valid && !out_ready.

Reset
REQ-023 SHALL, on rst, force state=IDLE, counter=0, out_valid=0, result=0, flags=0, out_err=0, busy=0; in_ready is 1 on the first cycle after rst deasserts.
REQ-024 SHALL abort any in-progress shift on rst with no result produced.

Configuration
REQ-025 SHALL use macro ALU_PIPE_BARREL_EN: when defined, lsl/asr use a single-cycle barrel shifter, latency 1, SHIFT state never entered and busy tied 0.
REQ-026 SHALL, without ALU_PIPE_BARREL_EN, use the iterative shifter of REQ-018 with latency amt+1 cycles (1 for amt=0).

Verification
REQ-027 SHALL test add 0xFFFFFFFF+0x00000001 -> result 0x00000000, flags N0 Z1 C1 V0, out_valid one cycle after accept.
REQ-028 SHALL test sub 0x80000000-0x00000001 -> result 0x7FFFFFFF, N0 Z0 C1 V1.
REQ-029 SHALL test asr A=0x80000010 amt=4 (iterative) -> result 0xF8000001, C=0, busy 4 cycles, out_valid 5 cycles after accept; barrel build -> 1 cycle.
REQ-030 SHALL test undefined opcode 01100 -> result 0, Z=1, out_err=1.
REQ-031 SHALL test back-pressure: out_ready=0 for 3 cycles with second op offered -> in_ready 0, result stable, second op accepted on the out_ready cycle, its result next cycle.
REQ-032 SHALL test rst asserted mid-lsl (amt=20, cycle 5) -> out_valid 0, busy 0, in_ready 1 the cycle after rst release, no stale result.
